alpha_aggregator: RTL and testbench

- Receiving end of the softmax output interface. Captures each attention-coefficient frame (alpha vector, neighbour count) on the softmax ready strobe.
- Fetches the matching neighbour WH feature rows from the WH buffer.
- Computes the weighted sum h'_i = sum_j alpha_j * WH_j over all output features.
- Presents the aggregated feature vector to the next stage using a valid/ready handshake.

---
 rtl/alpha_aggregator_pkg.sv | 37 +++
 rtl/alpha_aggregator_frame_fifo.sv | 58 +++++
 rtl/alpha_aggregator.sv | 142 ++++++++++++++
 tb/tb_alpha_aggregator.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alpha_aggregator_pkg.sv
// Shared widths, frame record and output scaling for the alpha aggregator.
// The scaling helper is the only place where accumulator-to-output rounding lives.
package alpha_aggregator_pkg;

  localparam int NUM_OF_NODES     = 16;
  localparam int NUM_NODE_WIDTH   = 5;
  localparam int ALPHA_DATA_WIDTH = 9;
  localparam int ALPHA_FRAC       = 8;
  localparam int NUM_FEATURE_OUT  = 4;
  localparam int WH_DATA_WIDTH    = 16;
  localparam int WH_ADDR_W        = 10;
  localparam int OUT_DATA_WIDTH   = 16;
  localparam int IDX_W            = $clog2(NUM_OF_NODES);
  localparam int PROD_W           = WH_DATA_WIDTH + ALPHA_DATA_WIDTH + 1;
  localparam int ACC_W            = PROD_W + IDX_W;
  localparam int SH_W             = ACC_W - ALPHA_FRAC;

  typedef struct packed {
    logic [NUM_OF_NODES*ALPHA_DATA_WIDTH-1:0] alpha;
    logic [NUM_NODE_WIDTH-1:0]                n;
    logic [WH_ADDR_W-1:0]                     base;
  } frame_t;

  // Dropping the fraction bits of a two's-complement value floors toward -inf.
  function automatic logic [OUT_DATA_WIDTH-1:0] scale_sat(input logic signed [ACC_W-1:0] acc);
    logic [SH_W-1:0] sh;
    sh = acc[ACC_W-1:ALPHA_FRAC];
    if ((&sh[SH_W-1:OUT_DATA_WIDTH-1]) || (~|sh[SH_W-1:OUT_DATA_WIDTH-1])) begin
      return sh[OUT_DATA_WIDTH-1:0];
    end else if (sh[SH_W-1]) begin
      return {1'b1, {(OUT_DATA_WIDTH-1){1'b0}}};
    end else begin
      return {1'b0, {(OUT_DATA_WIDTH-1){1'b1}}};
    end
  endfunction

endpackage

// File: rtl/alpha_aggregator_frame_fifo.sv
// Two-entry frame buffer between the softmax strobe and the aggregation FSM.
// A push into a full buffer is only accepted when a pop happens in the same cycle.
module agg_frame_fifo
  import alpha_aggregator_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  frame_t push_data,
  input  logic   pop,
  output frame_t head,
  output logic   empty,
  output logic   overflow
);

  frame_t     mem_r [2];
  logic       wr_ptr_r;
  logic       rd_ptr_r;
  logic [1:0] count_r;
  logic       overflow_r;
  logic       full_s;
  logic       push_ok_s;
  logic       pop_ok_s;

  assign full_s    = (count_r == 2'd2);
  assign empty     = (count_r == 2'd0);
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full_s || pop_ok_s);
  assign head      = mem_r[rd_ptr_r];
  assign overflow  = overflow_r;

  // Storage, pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r[0]   <= '0;
      mem_r[1]   <= '0;
      wr_ptr_r   <= 1'b0;
      rd_ptr_r   <= 1'b0;
      count_r    <= 2'd0;
      overflow_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
      overflow_r <= overflow_r | (push && !push_ok_s);
    end
  end

endmodule

// File: rtl/alpha_aggregator.sv
// Weighted neighbour aggregation: h'_i = sum_j alpha_j * WH_j, one frame at a time.
// Frames are buffered, WH rows are fetched back-to-back, and the result is held until accepted.
module alpha_aggregator
  import alpha_aggregator_pkg::*;
(
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     sm_ready_i,
  input  logic [NUM_OF_NODES*ALPHA_DATA_WIDTH-1:0] alpha_i,
  input  logic [NUM_NODE_WIDTH-1:0]                sm_num_of_nodes_i,
  input  logic [WH_ADDR_W-1:0]                     wh_base_i,
  output logic                                     wh_rd_en_o,
  output logic [WH_ADDR_W-1:0]                     wh_rd_addr_o,
  input  logic [NUM_FEATURE_OUT*WH_DATA_WIDTH-1:0] wh_rd_data_i,
  output logic                                     agg_valid_o,
  input  logic                                     agg_ready_i,
  output logic [NUM_FEATURE_OUT*OUT_DATA_WIDTH-1:0] agg_data_o,
  output logic                                     overflow_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  logic [1:0]                               state_r;
  logic [NUM_OF_NODES*ALPHA_DATA_WIDTH-1:0] alpha_r;
  logic [NUM_NODE_WIDTH-1:0]                n_r;
  logic [NUM_NODE_WIDTH-1:0]                j_r;
  logic                                     rd_en_d_r;
  logic [IDX_W-1:0]                         k_r;
  logic signed [ACC_W-1:0]                  acc_r      [NUM_FEATURE_OUT];
  logic signed [ACC_W-1:0]                  acc_next_s [NUM_FEATURE_OUT];
  logic signed [PROD_W-1:0]                 prod_s     [NUM_FEATURE_OUT];
  logic [NUM_FEATURE_OUT*OUT_DATA_WIDTH-1:0] data_next_s;
  logic [ALPHA_DATA_WIDTH-1:0]              alpha_k_s;
  logic                                     pop_s;
  logic                                     empty_s;
  frame_t                                   head_s;
  frame_t                                   push_frame_s;
  logic [NUM_NODE_WIDTH-1:0]                head_n_s;

  assign push_frame_s = '{alpha: alpha_i, n: sm_num_of_nodes_i, base: wh_base_i};
  assign pop_s        = (state_r == ST_IDLE) && !empty_s;
  assign head_n_s     = (head_s.n > NUM_NODE_WIDTH'(NUM_OF_NODES)) ?
                        NUM_NODE_WIDTH'(NUM_OF_NODES) : head_s.n;
  assign alpha_k_s    = alpha_r[k_r*ALPHA_DATA_WIDTH +: ALPHA_DATA_WIDTH];

  agg_frame_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (sm_ready_i),
    .push_data (push_frame_s),
    .pop       (pop_s),
    .head      (head_s),
    .empty     (empty_s),
    .overflow  (overflow_o)
  );

  // MAC: the row arriving this cycle belongs to the read issued last cycle (index k_r).
  always_comb begin
    data_next_s = '0;
    for (int f = 0; f < NUM_FEATURE_OUT; f++) begin
      prod_s[f] = PROD_W'($signed(wh_rd_data_i[f*WH_DATA_WIDTH +: WH_DATA_WIDTH])) *
                  PROD_W'($signed({1'b0, alpha_k_s}));
      if (rd_en_d_r) begin
        acc_next_s[f] = acc_r[f] + ACC_W'(prod_s[f]);
      end else begin
        acc_next_s[f] = acc_r[f];
      end
      data_next_s[f*OUT_DATA_WIDTH +: OUT_DATA_WIDTH] = scale_sat(acc_next_s[f]);
    end
  end

  // Frame sequencing, read issue, accumulation and the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      alpha_r      <= '0;
      n_r          <= '0;
      j_r          <= '0;
      rd_en_d_r    <= 1'b0;
      k_r          <= '0;
      wh_rd_en_o   <= 1'b0;
      wh_rd_addr_o <= '0;
      agg_valid_o  <= 1'b0;
      agg_data_o   <= '0;
      for (int f = 0; f < NUM_FEATURE_OUT; f++) begin
        acc_r[f] <= '0;
      end
    end else begin
      rd_en_d_r <= wh_rd_en_o;
      k_r       <= j_r[IDX_W-1:0];
      for (int f = 0; f < NUM_FEATURE_OUT; f++) begin
        acc_r[f] <= acc_next_s[f];
      end
      case (state_r)
        ST_IDLE: begin
          if (!empty_s) begin
            alpha_r <= head_s.alpha;
            n_r     <= head_n_s;
            j_r     <= '0;
            for (int f = 0; f < NUM_FEATURE_OUT; f++) begin
              acc_r[f] <= '0;
            end
            if (head_n_s != '0) begin
              state_r      <= ST_FETCH;
              wh_rd_en_o   <= 1'b1;
              wh_rd_addr_o <= head_s.base;
            end else begin
              state_r     <= ST_OUT;
              agg_valid_o <= 1'b1;
              agg_data_o  <= '0;
            end
          end
        end
        ST_FETCH: begin
          if (j_r == (n_r - NUM_NODE_WIDTH'(1))) begin
            wh_rd_en_o <= 1'b0;
            state_r    <= ST_DRAIN;
          end else begin
            j_r          <= j_r + NUM_NODE_WIDTH'(1);
            wh_rd_addr_o <= wh_rd_addr_o + WH_ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          state_r     <= ST_OUT;
          agg_valid_o <= 1'b1;
          agg_data_o  <= data_next_s;
        end
        ST_OUT: begin
          if (agg_ready_i) begin
            agg_valid_o <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alpha_aggregator.sv
// Directed bench for alpha_aggregator: a vector table plus hand-written sequences
// for backpressure, FIFO overflow, reset mid-frame and the full-push-with-pop case.
module tb_alpha_aggregator;
  import alpha_aggregator_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sm_ready_i = 1'b0;
  logic [143:0] alpha_i = '0;
  logic [4:0]   sm_num_of_nodes_i = '0;
  logic [9:0]   wh_base_i = '0;
  logic         wh_rd_en_o;
  logic [9:0]   wh_rd_addr_o;
  logic [63:0]  wh_rd_data_i;
  logic         agg_valid_o;
  logic         agg_ready_i = 1'b0;
  logic [63:0]  agg_data_o;
  logic         overflow_o;

  alpha_aggregator dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .sm_ready_i        (sm_ready_i),
    .alpha_i           (alpha_i),
    .sm_num_of_nodes_i (sm_num_of_nodes_i),
    .wh_base_i         (wh_base_i),
    .wh_rd_en_o        (wh_rd_en_o),
    .wh_rd_addr_o      (wh_rd_addr_o),
    .wh_rd_data_i      (wh_rd_data_i),
    .agg_valid_o       (agg_valid_o),
    .agg_ready_i       (agg_ready_i),
    .agg_data_o        (agg_data_o),
    .overflow_o        (overflow_o)
  );

  always #5 clk = ~clk;

  // WH buffer model: one-cycle read latency, plus a log of every issued read.
  logic [63:0] mem [1024];
  logic        rd_pend = 1'b0;
  logic [9:0]  rd_addr_q = '0;
  int          cyc = 0;
  int          rd_addr_log [$];
  int          rd_cyc_log  [$];

  assign wh_rd_data_i = rd_pend ? mem[rd_addr_q] : 64'd0;

  always @(posedge clk) begin
    if (wh_rd_en_o === 1'b1) begin
      rd_addr_log.push_back(int'(wh_rd_addr_o));
      rd_cyc_log.push_back(cyc);
    end
    rd_pend   <= wh_rd_en_o;
    rd_addr_q <= wh_rd_addr_o;
    cyc       <= cyc + 1;
  end

  typedef struct packed {
    logic [4:0]    n;
    logic [9:0]    base;
    logic [143:0]  alpha;
    logic [1023:0] rows;
    logic [63:0]   expd;
  } vec_t;

  vec_t vecs [8];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [63:0] row4(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic logic [143:0] alpha_all(input int v);
    logic [143:0] r;
    r = '0;
    for (int j = 0; j < 16; j++) r[j*9 +: 9] = 9'(v);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input int limit, output bit got, output int vc);
    got = 1'b0;
    vc  = 0;
    for (int i = 0; i < limit; i++) begin
      if (agg_valid_o === 1'b1) begin
        got = 1'b1;
        vc  = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic strobe(input logic [4:0] n, input logic [9:0] base, input logic [143:0] alpha);
    sm_ready_i = 1'b1; sm_num_of_nodes_i = n; wh_base_i = base; alpha_i = alpha;
    @(negedge clk);
    sm_ready_i = 1'b0;
  endtask

  task automatic wait_out(input string name, input logic [63:0] exp);
    bit got;
    int vc;
    wait_valid(200, got, vc);
    check({name, "_valid"}, 64'(got), 64'd1);
    if (got) check({name, "_data"}, agg_data_o, exp);
    agg_ready_i = 1'b1;
    @(negedge clk);
    agg_ready_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int ne, s_cyc, vc, bad;
    bit got;
    ne = (v.n > 5'd16) ? 16 : int'(v.n);
    for (int j = 0; j < ne; j++) mem[(int'(v.base) + j) % 1024] = v.rows[j*64 +: 64];
    rd_addr_log.delete();
    rd_cyc_log.delete();
    s_cyc = cyc;
    strobe(v.n, v.base, v.alpha);
    wait_valid(200, got, vc);
    check({name, "_valid"}, 64'(got), 64'd1);
    if (got) begin
      check({name, "_data"}, agg_data_o, v.expd);
      check({name, "_nreads"}, 64'(rd_addr_log.size()), 64'(ne));
      bad = 0;
      foreach (rd_addr_log[i]) if (rd_addr_log[i] != (int'(v.base) + i) % 1024) bad++;
      check({name, "_addrs_bad"}, 64'(bad), 64'd0);
      if (ne > 0 && rd_cyc_log.size() == ne) begin
        check({name, "_first_rd"}, 64'(rd_cyc_log[0] - s_cyc), 64'd2);
        check({name, "_b2b"}, 64'(rd_cyc_log[ne-1] - rd_cyc_log[0]), 64'(ne - 1));
        check({name, "_latency"}, 64'(vc - rd_cyc_log[0]), 64'(ne + 1));
      end else if (ne == 0) begin
        check({name, "_zero_lat"}, 64'(vc - s_cyc), 64'd2);
      end
    end
    agg_ready_i = 1'b1;
    @(negedge clk);
    agg_ready_i = 1'b0;
    check({name, "_valid_drop"}, 64'(agg_valid_o), 64'd0);
  endtask

  initial begin
    vec_t v;
    bit   got;
    int   vc, r_cyc, cnt;

    v = '0; v.n = 5'd2; v.base = 10'h010; v.alpha[0 +: 9] = 9'd128; v.alpha[9 +: 9] = 9'd128;
    v.rows[0 +: 64] = row4(10, -4, 0, 0); v.rows[64 +: 64] = row4(20, 8, 0, 0);
    v.expd = row4(15, 2, 0, 0); vecs[0] = v;

    v = '0; v.n = 5'd1; v.base = 10'h020; v.alpha[0 +: 9] = 9'd1;
    v.rows[0 +: 64] = row4(-1, 1, 255, 256); v.expd = row4(-1, 0, 0, 1); vecs[1] = v;

    v = '0; v.n = 5'd16; v.base = 10'h100; v.alpha = alpha_all(256);
    for (int j = 0; j < 16; j++) v.rows[j*64 +: 64] = row4(32767, -32768, 32767, -32768);
    v.expd = row4(32767, -32768, 32767, -32768); vecs[2] = v;

    v = '0; v.n = 5'd0; v.base = 10'h050; v.alpha = alpha_all(200); v.expd = 64'd0; vecs[3] = v;

    v = '0; v.n = 5'd2; v.base = 10'h3FF; v.alpha[0 +: 9] = 9'd256; v.alpha[9 +: 9] = 9'd64;
    v.rows[0 +: 64] = row4(100, -100, 7, 0); v.rows[64 +: 64] = row4(400, 4, -8, 1000);
    v.expd = row4(200, -99, 5, 250); vecs[4] = v;

    v = '0; v.n = 5'd1; v.base = 10'h060; v.alpha = alpha_all(511); v.alpha[0 +: 9] = 9'd256;
    v.rows[0 +: 64] = row4(3, -3, 0, 0); v.expd = row4(3, -3, 0, 0); vecs[5] = v;

    v = '0; v.n = 5'd20; v.base = 10'h140; v.alpha = alpha_all(16);
    for (int j = 0; j < 16; j++) v.rows[j*64 +: 64] = row4(16, -16, 1, 0);
    v.expd = row4(16, -16, 1, 0); vecs[6] = v;

    v = '0; v.n = 5'd3; v.base = 10'h030;
    v.alpha[0 +: 9] = 9'd100; v.alpha[9 +: 9] = 9'd200; v.alpha[18 +: 9] = 9'd50;
    v.rows[0 +: 64] = row4(1000, 0, -1, 0); v.rows[64 +: 64] = row4(-500, 3, -1, 0);
    v.rows[128 +: 64] = row4(2000, -7, -1, 0); v.expd = row4(390, 0, -2, 0); vecs[7] = v;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rd_en", 64'(wh_rd_en_o), 64'd0);
    check("rst_rd_addr", 64'(wh_rd_addr_o), 64'd0);
    check("rst_valid", 64'(agg_valid_o), 64'd0);
    check("rst_data", agg_data_o, 64'd0);
    check("rst_overflow", 64'(overflow_o), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure, with a second frame buffered while the first waits
    strobe(5'd2, 10'h010, vecs[0].alpha);
    mem[10'h040] = row4(1, 2, 3, 4);
    wait_valid(200, got, vc);
    check("bp_valid", 64'(got), 64'd1);
    rd_addr_log.delete();
    rd_cyc_log.delete();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold_valid%0d", i), 64'(agg_valid_o), 64'd1);
      check($sformatf("bp_hold_data%0d", i), agg_data_o, row4(15, 2, 0, 0));
      if (i == 1) strobe(5'd1, 10'h040, alpha_all(256));
      else @(negedge clk);
    end
    agg_ready_i = 1'b1;
    r_cyc = cyc;
    @(negedge clk);
    agg_ready_i = 1'b0;
    check("bp_valid_drop", 64'(agg_valid_o), 64'd0);
    wait_valid(200, got, vc);
    check("bp_f2_valid", 64'(got), 64'd1);
    if (rd_cyc_log.size() == 1) check("bp_idle_pop", 64'(rd_cyc_log[0] - r_cyc), 64'd2);
    else check("bp_f2_nreads", 64'(rd_cyc_log.size()), 64'd1);
    check("bp_f2_data", agg_data_o, row4(1, 2, 3, 4));
    agg_ready_i = 1'b1;
    @(negedge clk);
    agg_ready_i = 1'b0;

    // FIFO stress: B, C buffered, D dropped; E pushed into a full FIFO while B pops
    for (int j = 0; j < 16; j++) mem[10'h200 + j] = row4(1, 2, 3, 4);
    mem[10'h300] = row4(5, 6, 7, 8);
    mem[10'h301] = row4(-9, -10, -11, -12);
    mem[10'h302] = row4(77, 77, 77, 77);
    mem[10'h303] = row4(-100, 200, -300, 400);
    strobe(5'd16, 10'h200, alpha_all(256));
    repeat (3) @(negedge clk);
    check("ovf_before", 64'(overflow_o), 64'd0);
    sm_ready_i = 1'b1; sm_num_of_nodes_i = 5'd1; alpha_i = alpha_all(256);
    wh_base_i = 10'h300; @(negedge clk);
    wh_base_i = 10'h301; @(negedge clk);
    wh_base_i = 10'h302; @(negedge clk);
    sm_ready_i = 1'b0;
    check("ovf_set", 64'(overflow_o), 64'd1);
    wait_valid(200, got, vc);
    check("stress_L_valid", 64'(got), 64'd1);
    check("stress_L_data", agg_data_o, row4(16, 32, 48, 64));
    agg_ready_i = 1'b1;
    @(negedge clk);
    agg_ready_i = 1'b0;
    strobe(5'd1, 10'h303, alpha_all(128));
    wait_out("stress_B", row4(5, 6, 7, 8));
    wait_out("stress_C", row4(-9, -10, -11, -12));
    wait_out("stress_E", row4(-50, 100, -150, 200));
    cnt = 0;
    repeat (40) begin
      if (agg_valid_o === 1'b1) cnt++;
      @(negedge clk);
    end
    check("stress_no_D", 64'(cnt), 64'd0);
    check("ovf_sticky", 64'(overflow_o), 64'd1);

    // Reset during FETCH with a frame buffered behind it
    for (int j = 0; j < 16; j++) mem[10'h080 + j] = row4(9, 9, 9, 9);
    strobe(5'd16, 10'h080, alpha_all(256));
    repeat (4) @(negedge clk);
    strobe(5'd1, 10'h080, alpha_all(256));
    check("rstmid_fetching", 64'(wh_rd_en_o), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid_rd_en", 64'(wh_rd_en_o), 64'd0);
    check("rstmid_rd_addr", 64'(wh_rd_addr_o), 64'd0);
    check("rstmid_valid", 64'(agg_valid_o), 64'd0);
    check("rstmid_data", agg_data_o, 64'd0);
    check("rstmid_overflow", 64'(overflow_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_addr_log.delete();
    rd_cyc_log.delete();
    cnt = 0;
    repeat (40) begin
      if (agg_valid_o === 1'b1) cnt++;
      @(negedge clk);
    end
    check("rstmid_no_valid", 64'(cnt), 64'd0);
    check("rstmid_no_reads", 64'(rd_addr_log.size()), 64'd0);
    run_vec(vecs[0], "post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
